// File: rtl/census_stereo_pkg.sv
// Shared width helpers for the census stereo matcher.
package census_stereo_pkg;

  // Width of a disparity index able to hold 0..num_disp-1.
  function automatic int disp_width(input int num_disp);
    return (num_disp > 1) ? $clog2(num_disp) : 1;
  endfunction

  // Width of a Hamming cost able to hold 0..census_w.
  function automatic int cost_width(input int census_w);
    return $clog2(census_w + 1);
  endfunction

  // Number of registered min-tree levels above the leaf costs.
  function automatic int tree_levels(input int num_disp);
    return $clog2(num_disp);
  endfunction

  // Node count at a given tree level: ceil(n / 2^level).
  function automatic int level_nodes(input int n, input int level);
    return (n + (1 << level) - 1) >> level;
  endfunction

  // Saturated cost used to mark candidates without history.
  function automatic int cost_max(input int cost_w);
    return (1 << cost_w) - 1;
  endfunction

endpackage

// File: rtl/census_popcount.sv
// XOR of two census words followed by a population count (combinational).
module census_popcount #(
  parameter int CENSUS_W = 8,
  parameter int COST_W   = 4
) (
  input  logic [CENSUS_W-1:0] a_i,
  input  logic [CENSUS_W-1:0] b_i,
  output logic [COST_W-1:0]   cost_o
);

  logic [CENSUS_W-1:0] diff;

  assign diff = a_i ^ b_i;

  // Count differing bits.
  always_comb begin
    cost_o = '0;
    for (int i = 0; i < CENSUS_W; i++) begin
      cost_o = cost_o + COST_W'(diff[i]);
    end
  end

endmodule

// File: rtl/census_disparity_search.sv
// Streaming census-stereo disparity search for one scanline.
// Optional build macro: CENSUS_DISP_UNIQUE_EN (second-best tracking for out_unique).
// Node layout carried through the min-tree: {valid, cost, idx[, cost2, alone]}.
module census_disparity_search
  import census_stereo_pkg::*;
#(
  parameter int CENSUS_W = 8,
  parameter int NUM_DISP = 4,
  parameter int DISP_W   = disp_width(NUM_DISP),
  parameter int COST_W   = cost_width(CENSUS_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                in_sol,
  input  logic [CENSUS_W-1:0] lcensus,
  input  logic [CENSUS_W-1:0] rcensus,
  output logic                out_valid,
  output logic [DISP_W-1:0]   out_disp,
  output logic [COST_W-1:0]   out_cost,
  output logic                out_unique
);

  localparam int TREE_H = tree_levels(NUM_DISP);
  localparam logic [COST_W-1:0] COST_MAX = COST_W'(cost_max(COST_W));

  typedef struct packed {
    logic              valid;
    logic [COST_W-1:0] cost;
    logic [DISP_W-1:0] idx;
`ifdef CENSUS_DISP_UNIQUE_EN
    logic [COST_W-1:0] cost2;   // best cost among the other candidates of this subtree
    logic              alone;   // no other valid candidate in this subtree
`endif
  } node_t;

  function automatic node_t make_leaf(input logic valid, input logic [COST_W-1:0] cost,
                                      input logic [DISP_W-1:0] idx);
    node_t n;
    n       = '0;
    n.valid = valid;
    n.cost  = valid ? cost : COST_MAX;
    n.idx   = idx;
`ifdef CENSUS_DISP_UNIQUE_EN
    n.cost2 = COST_MAX;
    n.alone = 1'b1;
`endif
    return n;
  endfunction

`ifdef CENSUS_DISP_UNIQUE_EN
  function automatic logic [COST_W-1:0] min_cost(input logic [COST_W-1:0] a,
                                                 input logic [COST_W-1:0] b);
    return (b < a) ? b : a;
  endfunction
`endif

  // lo always holds lower disparity indices than hi, so ties go to lo.
  function automatic node_t pick(input node_t lo, input node_t hi);
    node_t w;
    logic  hi_wins;
    hi_wins = hi.valid && (!lo.valid || (hi.cost < lo.cost));
    w       = hi_wins ? hi : lo;
`ifdef CENSUS_DISP_UNIQUE_EN
    begin
      node_t l;
      l       = hi_wins ? lo : hi;
      w.cost2 = min_cost(min_cost(w.cost2, l.cost), l.cost2);
      w.alone = w.alone & ~l.valid;
    end
`endif
    return w;
  endfunction

  // Right-word history; after an update it is also the stage-1 window for the
  // pixel just accepted, since it only moves again on the next accepted pixel.
  logic [CENSUS_W-1:0] r_q [NUM_DISP];
  logic                h_q [NUM_DISP];
  logic [CENSUS_W-1:0] l_q;
  logic                s1_vld_q;

  // Shift the right window and history bits on each accepted pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < NUM_DISP; d++) begin
        r_q[d] <= '0;
        h_q[d] <= 1'b0;
      end
    end else if (in_valid) begin
      r_q[0] <= rcensus;
      h_q[0] <= 1'b1;
      for (int d = 1; d < NUM_DISP; d++) begin
        r_q[d] <= r_q[d-1];
        h_q[d] <= h_q[d-1] & ~in_sol;
      end
    end
  end

  // Stage 1: capture the left word alongside the updated window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_q      <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= in_valid;
      if (in_valid) l_q <= lcensus;
    end
  end

  // Level 0 holds per-disparity costs; levels 1..TREE_H reduce pairwise.
  for (genvar gi = 0; gi <= TREE_H; gi++) begin : lvl
    localparam int NODES = level_nodes(NUM_DISP, gi);
    node_t node_d [NODES];
    node_t node_q [NODES];
    logic  vld_in;
    logic  vld_q;

    if (gi == 0) begin : g_leaf
      assign vld_in = s1_vld_q;
      for (genvar gj = 0; gj < NODES; gj++) begin : g_pc
        logic [COST_W-1:0] pc;
        census_popcount #(.CENSUS_W(CENSUS_W), .COST_W(COST_W)) u_pc (
          .a_i   (l_q),
          .b_i   (r_q[gj]),
          .cost_o(pc)
        );
        assign node_d[gj] = make_leaf(h_q[gj], pc, DISP_W'(gj));
      end
    end else begin : g_node
      localparam int PREV = level_nodes(NUM_DISP, gi - 1);
      assign vld_in = lvl[gi-1].vld_q;
      for (genvar gj = 0; gj < NODES; gj++) begin : g_min
        if (2 * gj + 1 < PREV) begin : g_pair
          assign node_d[gj] = pick(lvl[gi-1].node_q[2*gj], lvl[gi-1].node_q[2*gj+1]);
        end else begin : g_pass
          assign node_d[gj] = lvl[gi-1].node_q[2*gj];
        end
      end
    end

    // Advance valid every cycle; load data only with a real result so it holds.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= 1'b0;
        for (int j = 0; j < NODES; j++) node_q[j] <= '0;
      end else begin
        vld_q <= vld_in;
        if (vld_in) begin
          for (int j = 0; j < NODES; j++) node_q[j] <= node_d[j];
        end
      end
    end
  end

  // Root valid bit has no consumer: d=0 is always a valid candidate.
  logic unused_root_valid;
  assign unused_root_valid = lvl[TREE_H].node_q[0].valid;

  assign out_valid = lvl[TREE_H].vld_q;
  assign out_disp  = lvl[TREE_H].node_q[0].idx;
  assign out_cost  = lvl[TREE_H].node_q[0].cost;

`ifdef CENSUS_DISP_UNIQUE_EN
  assign out_unique = lvl[TREE_H].node_q[0].alone |
                      (lvl[TREE_H].node_q[0].cost < lvl[TREE_H].node_q[0].cost2);
`else
  assign out_unique = out_valid;
`endif

endmodule

// File: tb/tb_census_disparity_search.sv
// Self-checking bench: directed and random scanlines against two configurations
// (8-bit/4 disparities and 16-bit/5 disparities) with a behavioural reference.
module tb_census_disparity_search;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sol = 1'b0;
  logic [7:0]  lc_a = '0, rc_a = '0;
  logic [15:0] lc_b = '0, rc_b = '0;

  logic        ov_a, ou_a;
  logic [1:0]  od_a;
  logic [3:0]  oc_a;
  logic        ov_b, ou_b;
  logic [2:0]  od_b;
  logic [4:0]  oc_b;

  census_disparity_search u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sol    (in_sol),
    .lcensus   (lc_a),
    .rcensus   (rc_a),
    .out_valid (ov_a),
    .out_disp  (od_a),
    .out_cost  (oc_a),
    .out_unique(ou_a)
  );

  census_disparity_search #(.CENSUS_W(16), .NUM_DISP(5)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sol    (in_sol),
    .lcensus   (lc_b),
    .rcensus   (rc_b),
    .out_valid (ov_b),
    .out_disp  (od_b),
    .out_cost  (oc_b),
    .out_unique(ou_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int disp;
    int cost;
    bit uniq;
  } exp_t;

  exp_t        expq [2][$];
  exp_t        last [2];
  logic [31:0] hist [2][64];
  int          cnt  [2];
  int          nd   [2] = '{4, 5};
  int          lat  [2] = '{4, 5};   // 2 + ceil(log2(NUM_DISP))
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_total++;
    assert (obs === req) n_pass++;
    else $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, req);
  endtask

  task automatic model_reset(input int i);
    expq[i].delete();
    cnt[i]  = 0;
    last[i] = '{due: 0, disp: 0, cost: 0, uniq: 1'b0};
  endtask

  // Cheapest candidate among the columns seen since line start, lowest d on ties.
  task automatic accept(input int i, input logic [31:0] l, input logic [31:0] r, input bit sol);
    int   best, nbest, c;
    exp_t e;
    for (int d = 63; d > 0; d--) hist[i][d] = hist[i][d-1];
    hist[i][0] = r;
    cnt[i] = sol ? 1 : ((cnt[i] < nd[i]) ? cnt[i] + 1 : nd[i]);
    best = 1 << 30;
    nbest = 0;
    e.disp = 0;
    for (int d = 0; d < cnt[i]; d++) begin
      c = $countones(l ^ hist[i][d]);
      if (c < best) begin
        best = c;
        e.disp = d;
        nbest = 1;
      end else if (c == best) begin
        nbest++;
      end
    end
    e.cost = best;
    e.uniq = (nbest == 1);
    e.due  = cyc + lat[i];
    expq[i].push_back(e);
  endtask

  task automatic check_dut(input int i, input logic v, input logic [31:0] disp,
                           input logic [31:0] cost, input logic u);
    bit          ev;
    logic [31:0] eu;
    ev = (expq[i].size() > 0) && (expq[i][0].due == cyc);
    if (ev) last[i] = expq[i].pop_front();
`ifdef CENSUS_DISP_UNIQUE_EN
    eu = 32'(last[i].uniq);
`else
    eu = 32'(ev);
`endif
    chk($sformatf("dut%0d_valid", i), 32'(v), 32'(ev));
    chk($sformatf("dut%0d_disp", i), disp, last[i].disp);
    chk($sformatf("dut%0d_cost", i), cost, last[i].cost);
    chk($sformatf("dut%0d_unique", i), 32'(u), eu);
  endtask

  // One clock: drive, update the model, then sample just after the edge.
  task automatic step(input bit rst, input bit v, input bit sol,
                      input logic [7:0] la, input logic [7:0] ra,
                      input logic [15:0] lb, input logic [15:0] rb);
    reset = rst; in_valid = v; in_sol = sol;
    lc_a = la; rc_a = ra; lc_b = lb; rc_b = rb;
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else if (v) begin
      accept(0, 32'(la), 32'(ra), sol);
      accept(1, 32'(lb), 32'(rb), sol);
    end
    @(posedge clk);
    cyc++;
    #1;
    check_dut(0, ov_a, 32'(od_a), 32'(oc_a), ou_a);
    check_dut(1, ov_b, 32'(od_b), 32'(oc_b), ou_b);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 8'h00, 8'h00, 16'h0000, 16'h0000);
  endtask

  initial begin
    logic [7:0]  ra_s [16];
    logic [15:0] rb_s [16];
    logic [7:0]  rr_a [8];
    logic [15:0] rr_b [8];
    logic [7:0]  la;
    logic [15:0] lb;
    bit          v, sol;

    model_reset(0);
    model_reset(1);

    // Reset held with in_valid high: nothing may come out.
    for (int k = 0; k < 5; k++)
      step(1, 1, 0, 8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom));

    // Constant all-ones line: every candidate costs 0, d=0 wins.
    step(0, 1, 1, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF);
    for (int k = 0; k < 7; k++) step(0, 1, 0, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF);

    // Shift match: left lags right by 2 (dut a) and 4 (dut b).
    for (int x = 0; x < 14; x++) begin
      ra_s[x] = 8'($urandom);
      rb_s[x] = 16'($urandom);
      la = (x >= 2) ? ra_s[x-2] : 8'($urandom);
      lb = (x >= 4) ? rb_s[x-4] : 16'($urandom);
      step(0, 1, (x == 0), la, ra_s[x], lb, rb_s[x]);
    end

    // Tie: all candidates equally bad, lowest disparity wins.
    for (int x = 0; x < 7; x++) step(0, 1, (x == 0), 8'hF0, 8'h0F, 16'hFF00, 16'h00FF);

    // Warm-up after line start.
    step(0, 1, 1, 8'h00, 8'hFF, 16'h0000, 16'hFFFF);
    for (int x = 0; x < 3; x++) step(0, 1, 0, 8'h00, 8'h00, 16'h0000, 16'h0000);
    idle(6);

    // Bubbles: valid every other cycle.
    for (int k = 0; k < 14; k++)
      step(0, (k % 2 == 0), (k == 0), 8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom));
    idle(2);

    // Mid-line reset with results in flight, then restart without in_sol.
    for (int k = 0; k < 3; k++)
      step(0, 1, (k == 0), 8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom));
    step(1, 1, 0, 8'h12, 8'h34, 16'h1234, 16'h5678);
    step(1, 0, 0, 8'h00, 8'h00, 16'h0000, 16'h0000);
    step(0, 1, 0, 8'h00, 8'hFF, 16'h0000, 16'hFFFF);
    for (int x = 0; x < 3; x++) step(0, 1, 0, 8'h00, 8'h00, 16'h0000, 16'h0000);
    idle(6);

    // Random traffic: left near a recent right word, occasional bit flips.
    for (int k = 0; k < 8; k++) begin
      rr_a[k] = 8'($urandom);
      rr_b[k] = 16'($urandom);
    end
    for (int k = 0; k < 90; k++) begin
      v   = ($urandom_range(0, 9) < 7);
      sol = v && ($urandom_range(0, 15) == 0);
      la  = rr_a[$urandom_range(0, 5)] ^
            (($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      lb  = rr_b[$urandom_range(0, 5)] ^
            (($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0000);
      if (v) begin
        for (int j = 7; j > 0; j--) begin
          rr_a[j] = rr_a[j-1];
          rr_b[j] = rr_b[j-1];
        end
        rr_a[0] = 8'($urandom);
        rr_b[0] = 16'($urandom);
      end
      step(0, v, sol, la, rr_a[0], lb, rr_b[0]);
    end
    idle(8);

    // Every expected result must have emerged.
    chk("drain_a", 32'(expq[0].size()), 32'd0);
    chk("drain_b", 32'(expq[1].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
